// File: rtl/sc_core_rf_sb.sv
// Multi-port integer register file with busy-bit scoreboard.
// Define SC_CORE_RF_BYPASS_EN to forward same-cycle writes to readers.
module sc_core_rf_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_rd,
  input  logic                     flush,
  output logic                     busy_any
);

  logic [DATA_W-1:0]   regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] busy;
  logic [NUM_REGS-1:1] busy_nxt;
  logic [DATA_W-1:0]   rf [NUM_REGS];
  logic [NUM_REGS-1:0] bv;

  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
    assign wa[p] = wr_addr[p*ADDR_W +: ADDR_W];
    assign wd[p] = wr_data[p*DATA_W +: DATA_W];
  end

  // Write-back clears, then flush/issue; issue wins over a same-cycle clear.
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && wa[p] == ADDR_W'(r))
          busy_nxt[r] = 1'b0;
      end
      if (flush)
        busy_nxt[r] = 1'b0;
      else if (issue_en && issue_rd == ADDR_W'(r))
        busy_nxt[r] = 1'b1;
    end
  end

  // Higher-numbered write port is assigned last, so the load port wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int r = 1; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else begin
      busy <= busy_nxt;
      for (int r = 1; r < NUM_REGS; r++) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && wa[p] == ADDR_W'(r))
            regs[r] <= wd[p];
        end
      end
    end
  end

  always_comb begin
    rf[0] = '0;
    for (int r = 1; r < NUM_REGS; r++)
      rf[r] = regs[r];
    bv = {busy, 1'b0};
  end

  assign busy_any = |busy;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              b;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      d = rf[ra];
      b = bv[ra];
`ifdef SC_CORE_RF_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && ra != '0 && wa[p] == ra) begin
          d = wd[p];
          b = 1'b0;
        end
      end
`endif
    end

    assign rd_data[i*DATA_W +: DATA_W] = d;
    assign rd_busy[i] = b;
  end

endmodule

// File: tb/tb_sc_core_rf_sb.sv
// Self-checking bench for sc_core_rf_sb: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_sc_core_rf_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        busy_any;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic        m_busy [32];

  sc_core_rf_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .flush    (flush),
    .busy_any (busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] wa(int p);
    return wr_addr[p*5 +: 5];
  endfunction

  function automatic logic [31:0] wd(int p);
    return wr_data[p*32 +: 32];
  endfunction

  // Architectural effect of one clock edge on the model.
  task automatic model_commit();
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && wa(p) != 0) begin
          m_regs[wa(p)] = wd(p);
          m_busy[wa(p)] = 1'b0;
        end
      end
      if (flush) begin
        for (int r = 0; r < 32; r++)
          m_busy[r] = 1'b0;
      end else if (issue_en && issue_rd != 0) begin
        m_busy[issue_rd] = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] exp_data(logic [4:0] a);
    if (a == 0) return '0;
`ifdef SC_CORE_RF_BYPASS_EN
    if (wr_en[1] && wa(1) == a) return wd(1);
    if (wr_en[0] && wa(0) == a) return wd(0);
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef SC_CORE_RF_BYPASS_EN
    if (wr_en[1] && wa(1) == a) return 1'b0;
    if (wr_en[0] && wa(0) == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic exp_any();
    logic any = 1'b0;
    for (int r = 0; r < 32; r++)
      any |= m_busy[r];
    return any;
  endfunction

  task automatic idle();
    rst = 0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    issue_en = 0;
    issue_rd = '0;
    flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic wr(int p, logic [4:0] a, logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd_set(logic [4:0] a0, logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    idle();
    rd_addr = '0;
    rst = 1;
    step();
    step();
    idle();
    for (int a = 0; a < 32; a++) begin
      rd_set(5'(a), 5'(31 - a));
      if (rd_data !== 64'h0) begin
        errors++;
        $display("FAIL reset_data a=%0d got %h exp 0", a, rd_data);
      end
      if (rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_busy a=%0d got %b exp 00", a, rd_busy);
      end
      checks += 2;
    end
    checks++;
    if (busy_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_any got %b exp 0", busy_any);
    end
  endtask

  task automatic test_write_read();
    idle();
    wr(0, 5'd5, 32'hDEADBEEF);
    step();
    idle();
    rd_set(5'd5, 5'd5);
    checks++;
    if (rd_data !== {2{32'hDEADBEEF}}) begin
      errors++;
      $display("FAIL wr_rd5 got %h exp deadbeef x2", rd_data);
    end
    wr(0, 5'd0, 32'h1234);
    step();
    idle();
    rd_set(5'd0, 5'd5);
    checks++;
    if (rd_data !== {32'hDEADBEEF, 32'h0}) begin
      errors++;
      $display("FAIL wr_zero got %h exp deadbeef_00000000", rd_data);
    end
  endtask

  task automatic test_collision();
    idle();
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    step();
    idle();
    rd_set(5'd7, 5'd0);
    checks++;
    if (rd_data[31:0] !== 32'h22) begin
      errors++;
      $display("FAIL collision got %h exp 22", rd_data[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    issue_en = 1;
    issue_rd = 5'd3;
    step();
    idle();
    rd_set(5'd3, 5'd2);
    checks += 2;
    if (rd_busy !== 2'b01) begin
      errors++;
      $display("FAIL issue_busy got %b exp 01", rd_busy);
    end
    if (busy_any !== 1'b1) begin
      errors++;
      $display("FAIL issue_any got %b exp 1", busy_any);
    end
    wr(0, 5'd3, 32'h55);
    step();
    idle();
    rd_set(5'd3, 5'd3);
    checks += 3;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL wb_clear got %b exp 00", rd_busy);
    end
    if (rd_data[31:0] !== 32'h55) begin
      errors++;
      $display("FAIL wb_data got %h exp 55", rd_data[31:0]);
    end
    if (busy_any !== 1'b0) begin
      errors++;
      $display("FAIL wb_any got %b exp 0", busy_any);
    end
    wr(1, 5'd3, 32'h66);
    issue_en = 1;
    issue_rd = 5'd3;
    step();
    idle();
    rd_set(5'd3, 5'd0);
    checks += 2;
    if (rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL issue_wins got %b exp 1", rd_busy[0]);
    end
    if (rd_data[31:0] !== 32'h66) begin
      errors++;
      $display("FAIL issue_wb_data got %h exp 66", rd_data[31:0]);
    end
  endtask

  task automatic test_flush();
    idle();
    issue_en = 1;
    issue_rd = 5'd4;
    step();
    issue_rd = 5'd9;
    step();
    issue_rd = 5'd10;
    flush = 1;
    step();
    idle();
    rd_set(5'd4, 5'd9);
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL flush_4_9 got %b exp 00", rd_busy);
    end
    rd_set(5'd10, 5'd3);
    checks += 2;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL flush_10_3 got %b exp 00", rd_busy);
    end
    if (busy_any !== 1'b0) begin
      errors++;
      $display("FAIL flush_any got %b exp 0", busy_any);
    end
  endtask

  task automatic test_reset_priority();
    idle();
    wr(0, 5'd6, 32'h77);
    issue_en = 1;
    issue_rd = 5'd8;
    step();
    rst = 1;
    wr(0, 5'd6, 32'h99);
    issue_rd = 5'd8;
    step();
    idle();
    rd_set(5'd6, 5'd8);
    checks += 2;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("FAIL rst_dom_data got %h exp 0", rd_data);
    end
    if (rd_busy !== 2'b00 || busy_any !== 1'b0) begin
      errors++;
      $display("FAIL rst_dom_busy got %b/%b exp 00/0",
               rd_busy, busy_any);
    end
  endtask

  task automatic test_bypass();
    idle();
    wr(0, 5'd12, 32'h1111);
    step();
    issue_en = 1;
    issue_rd = 5'd12;
    wr_en = '0;
    step();
    idle();
    wr(0, 5'd12, 32'hA5A5A5A5);
    rd_set(5'd12, 5'd12);
    checks += 2;
`ifdef SC_CORE_RF_BYPASS_EN
    if (rd_data !== {2{32'hA5A5A5A5}}) begin
      errors++;
      $display("FAIL byp_data got %h exp a5a5a5a5 x2", rd_data);
    end
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL byp_busy got %b exp 00", rd_busy);
    end
`else
    if (rd_data !== {2{32'h1111}}) begin
      errors++;
      $display("FAIL nobyp_data got %h exp 1111 x2", rd_data);
    end
    if (rd_busy !== 2'b11) begin
      errors++;
      $display("FAIL nobyp_busy got %b exp 11", rd_busy);
    end
`endif
    step();
    idle();
    rd_set(5'd12, 5'd0);
    checks += 2;
    if (rd_data[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL byp_after got %h exp a5a5a5a5", rd_data[31:0]);
    end
    if (rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL byp_after_busy got %b exp 0", rd_busy[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      issue_en = $urandom_range(0, 1);
      issue_rd = 5'($urandom_range(0, 31));
      wr_en = 2'($urandom_range(0, 3));
      wr_addr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 3) == 0)
        wr_addr[9:5] = wr_addr[4:0];
      wr_data = {$urandom(), $urandom()};
      rd_addr = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 2) == 0)
        rd_addr[4:0] = wr_addr[4:0];
      #1;
      for (int i = 0; i < 2; i++) begin
        checks += 2;
        if (rd_data[i*32 +: 32] !== exp_data(rd_addr[i*5 +: 5])) begin
          errors++;
          $display("FAIL rnd_data n=%0d port=%0d a=%0d got %h exp %h",
                   n, i, rd_addr[i*5 +: 5], rd_data[i*32 +: 32],
                   exp_data(rd_addr[i*5 +: 5]));
        end
        if (rd_busy[i] !== exp_busy(rd_addr[i*5 +: 5])) begin
          errors++;
          $display("FAIL rnd_busy n=%0d port=%0d a=%0d got %b exp %b",
                   n, i, rd_addr[i*5 +: 5], rd_busy[i],
                   exp_busy(rd_addr[i*5 +: 5]));
        end
      end
      checks++;
      if (busy_any !== exp_any()) begin
        errors++;
        $display("FAIL rnd_any n=%0d got %b exp %b",
                 n, busy_any, exp_any());
      end
      step();
    end
    idle();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    rd_addr = '0;
    idle();
    test_reset();
    test_write_read();
    test_collision();
    test_scoreboard();
    test_flush();
    test_reset_priority();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
